// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq: iterative signed/unsigned WIDTH x WIDTH multiplier on one shared half-width vedic core, valid/ready on both sides.
// Optional: define VEDIC_MULT_SEQ_ZERO_SKIP_EN to bypass CALC when either operand is zero.
module vedic_mult #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W == 2) begin : g_base
    logic hh, hl, lh, c;
    assign hh = a[1] & b[1];
    assign hl = a[1] & b[0];
    assign lh = a[0] & b[1];
    assign c  = hl & lh;
    assign p  = {hh & c, hh ^ c, hl ^ lh, a[0] & b[0]};
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] ll, lh, hl, hh;
    vedic_mult #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_mult #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_mult #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_mult #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
    assign p = {{W{1'b0}}, ll} + {{H{1'b0}}, lh, {H{1'b0}}}
             + {{H{1'b0}}, hl, {H{1'b0}}} + {hh, {W{1'b0}}};
  end
endmodule

module vedic_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int H = WIDTH / 2;
  if (WIDTH != 16 && WIDTH != 32 && WIDTH != 64 && WIDTH != 128) begin : g_bad_width
    $error("vedic_mult_seq: WIDTH must be 16, 32, 64 or 128");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state;
  logic [1:0]         step;
  logic               sign;
  logic [WIDTH-1:0]   a_mag, b_mag, core_a, core_b, pp;
  logic [2*WIDTH-1:0] acc, pp_ext, acc_next;
  // step[1] picks the a half, step[0] the b half: lo*lo, lo*hi, hi*lo, hi*hi
  assign core_a   = step[1] ? a_mag[WIDTH-1:H] : a_mag[H-1:0];
  assign core_b   = step[0] ? b_mag[WIDTH-1:H] : b_mag[H-1:0];
  assign pp_ext   = step == 2'd0 ? {{WIDTH{1'b0}}, pp}
                  : step == 2'd3 ? {pp, {WIDTH{1'b0}}}
                  : {{H{1'b0}}, pp, {H{1'b0}}};
  assign acc_next = acc + pp_ext;
  vedic_mult #(.W(H)) u_core (.a(core_a), .b(core_b), .p(pp));
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      step      <= '0;
      sign      <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sign     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          a_mag    <= (is_signed & a[WIDTH-1]) ? -a : a;
          b_mag    <= (is_signed & b[WIDTH-1]) ? -b : b;
          acc      <= '0;
          step     <= '0;
          in_ready <= 1'b0;
`ifdef VEDIC_MULT_SEQ_ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            product   <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CALC;
          end
`else
          state <= CALC;
`endif
        end
        CALC: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            product   <= sign ? -acc_next : acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vedic_mult_seq.md
Name: vedic_mult_seq

Overview:
- Area-reduced iterative successor to the combinational recursive multiplier.
- One shared vedic_mult #(WIDTH/2) core computes a WIDTH x WIDTH product over four cycles, one half-width partial product per cycle, into a 2*WIDTH accumulator.
- Adds signed/unsigned mode per transaction and valid/ready handshakes on both sides, so it can sit between streaming datapath stages.

Parameters:
- WIDTH, 32, operand width. Legal values: 16, 32, 64, 128, so that WIDTH/2 is a legal core width of 8*2^k. Elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled at accept.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  downstream accepts the product.
- product  output  2*WIDTH  result. Registered; stable while out_valid = 1.

Behaviour:
- Clocking: one clock domain, clk. rst is synchronous and active-high.
- Reset: state = IDLE, in_ready = 1, out_valid = 0, product = 0, accumulator = 0, step counter = 0.
- Reset has priority over all other events, including reset asserted mid-CALC or in DONE. In-flight work is discarded and no out_valid is produced.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready at edge T, latch the operands and move to CALC.
    - Latched values: sign = is_signed & (a[MSB] ^ b[MSB]); a_mag = (is_signed & a[MSB]) ? -a : a; b_mag likewise. Magnitudes are WIDTH-bit unsigned.
    - Also: accumulator = 0, step = 0.
  - CALC: one step per edge, T+1 .. T+4 (H = WIDTH/2):
    - step 0: acc += a_lo*b_lo
    - step 1: acc += (a_lo*b_hi) << H
    - step 2: acc += (a_hi*b_lo) << H
    - step 3: acc += (a_hi*b_hi) << WIDTH
    - At the step-3 edge, product = sign ? -(acc_final) : acc_final, out_valid <= 1, state = DONE.
  - DONE: out_valid = 1, product held. On out_valid && out_ready, out_valid <= 0 and state = IDLE.
- Timing:
  - Latency: out_valid is first high in the cycle after edge T+4.
  - in_ready returns the cycle after the output handshake; there is no same-cycle re-accept.
  - Minimum initiation interval is 6 cycles.
- in_valid and operands are ignored outside IDLE. Upstream must hold them until accepted.
- Backpressure: out_ready low in DONE holds product and out_valid indefinitely. in_ready stays 0.
- Arithmetic:
  - The accumulator is 2*WIDTH bits wide and never overflows; the final magnitude is at most (2^WIDTH - 1)^2.
  - Most-negative case: -2^(W-1) has magnitude 2^(W-1), which fits unsigned. (-2^(W-1))^2 = 2^(2W-2) is representable.
  - Negation is two's complement over the full 2*WIDTH bits.
- The core is purely combinational. The partial-product mux selects core inputs from step. No other multipliers are inferred.

Optional Feature:
- Macro: VEDIC_MULT_SEQ_ZERO_SKIP_EN.
- Defined: at accept, if a == 0 or b == 0, go directly IDLE -> DONE with product = 0. out_valid is high the cycle after edge T (latency 1). CALC is skipped.
- Undefined: zero operands take the normal 4-step CALC path and the result is 0 with normal latency.

Test Plan:
- WIDTH=16, unsigned a=0xFFFF, b=0xFFFF accepted at edge T -> out_valid first high after T+4, product = 0xFFFE0001.
- Signed a=0xFFFD (-3), b=0x0005 -> product = 0xFFFFFFF1 (-15). Unsigned, same operands -> product = 0x0004FFF1.
- Signed a=0x8000, b=0x8000 -> product = 0x40000000. Signed a=0x8000, b=0x0001 -> product = 0xFFFF8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> product and out_valid stable, in_ready = 0, a new in_valid is ignored. Then pulse out_ready -> in_ready = 1 the next cycle, and the next transaction's result is correct.
- Reset: assert rst during CALC step 2 -> next cycle IDLE, in_ready = 1, out_valid = 0, product = 0. A following transaction 0x1234*0x5678 unsigned -> 0x06260060.
- a=0, b=0x1234: with the macro, out_valid after 1 cycle and product = 0. Without it, out_valid after 5 cycles and product = 0. Back-to-back random signed/unsigned stream of 1000 items matches the reference model.
